ele_motion_ctrl: RTL

//  Car motion and door sequencer for the 4-storey elevator. Consumes the direction

---
 rtl/ele_motion_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ele_motion_ctrl.sv
// ele_motion_ctrl
//   Car motion and door sequencer for a 4-storey elevator. It moves a one-hot
//   car position one floor at a time with timed travel, runs the door cycle
//   (opening, open dwell, closing) at each stop, and returns a served-floor
//   pulse so that the request processor can cancel the request it satisfied.
//
// Ports
//   clk        in   system clock (32 Hz), rising edge
//   rst_n      in   asynchronous active-low reset
//   ud_mode    in   [1:0] 00 stop, 01 up, 10 down, 11 treated as stop
//   stop_req   in   [3:0] pending requests per floor, bit0 = floor 1
//   open_btn   in   in-car door-open button (level)
//   close_btn  in   in-car door-close button (level)
//   obstruct   in   door-edge obstruction sensor (level)
//   position   out  [3:0] one-hot car floor
//   motor_up   out  high while moving up
//   motor_dn   out  high while moving down
//   door_open  out  high while the door is fully open
//   arrive     out  1-cycle pulse on each floor-boundary crossing
//   served     out  [3:0] 1-cycle copy of position on entry to the open state
//   state      out  [2:0] IDLE=0 MOVE_UP=1 MOVE_DN=2 OPENING=3 OPEN=4 CLOSING=5
module ele_motion_ctrl #(
  parameter int FLOOR_TICKS     = 64,
  parameter int DOOR_MOVE_TICKS = 32,
  parameter int DOOR_TICKS      = 96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ud_mode,
  input  logic [3:0] stop_req,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       obstruct,
  output logic [3:0] position,
  output logic       motor_up,
  output logic       motor_dn,
  output logic       door_open,
  output logic       arrive,
  output logic [3:0] served,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE_UP = 3'd1,
    MOVE_DN = 3'd2,
    OPENING = 3'd3,
    OPEN    = 3'd4,
    CLOSING = 3'd5
  } stateT;

  // Terminal counts: a phase lasting N ticks ends when cnt reaches N-1.
  localparam logic [7:0] FLOOR_LAST = 8'(FLOOR_TICKS - 1);
  localparam logic [7:0] DMOVE_LAST = 8'(DOOR_MOVE_TICKS - 1);
  localparam logic [7:0] DWELL_LAST = 8'(DOOR_TICKS - 1);

  stateT      curState;
  stateT      nxtState;
  logic [7:0] cnt;
  logic [7:0] nxtCnt;
  logic [3:0] nxtPos;
  logic [3:0] stepPos;
  logic [3:0] endPos;
  logic [1:0] dirMode;
  logic       nxtArrive;
  logic [3:0] nxtServed;
  logic       hitNow;

  // Shifts saturate at the shaft ends so the car can never leave the shaft.
  function automatic logic [3:0] shiftUp(input logic [3:0] p);
    return (p == 4'b1000) ? p : {p[2:0], 1'b0};
  endfunction

  function automatic logic [3:0] shiftDn(input logic [3:0] p);
    return (p == 4'b0001) ? p : {1'b0, p[3:1]};
  endfunction

  function automatic logic isOneHot(input logic [3:0] p);
    return (p != 4'b0000) && ((p & (p - 4'b0001)) == 4'b0000);
  endfunction

  assign hitNow = |(stop_req & position);
  assign state  = curState;

  // Next-state, counter, position and pulse computation.
  always_comb begin
    nxtState  = curState;
    nxtCnt    = cnt + 8'd1;
    nxtPos    = position;
    nxtArrive = 1'b0;
    nxtServed = 4'b0000;
    stepPos   = position;
    endPos    = 4'b1000;
    dirMode   = 2'b01;
    if (!isOneHot(position)) begin
      // A corrupted position cannot be trusted: park at floor 1 with the car stopped.
      nxtState = IDLE;
      nxtPos   = 4'b0001;
      nxtCnt   = 8'd0;
    end else begin
      case (curState)
        IDLE: begin
          nxtCnt = 8'd0;
          if (hitNow || open_btn) begin
            nxtState = OPENING;
          end else if ((ud_mode == 2'b01) && (position != 4'b1000)) begin
            nxtState = MOVE_UP;
          end else if ((ud_mode == 2'b10) && (position != 4'b0001)) begin
            nxtState = MOVE_DN;
          end else begin
            nxtState = IDLE;
          end
        end
        MOVE_UP, MOVE_DN: begin
          if (cnt == FLOOR_LAST) begin
            if (curState == MOVE_UP) begin
              stepPos = shiftUp(position);
              endPos  = 4'b1000;
              dirMode = 2'b01;
            end else begin
              stepPos = shiftDn(position);
              endPos  = 4'b0001;
              dirMode = 2'b10;
            end
            nxtPos    = stepPos;
            nxtArrive = 1'b1;
            nxtCnt    = 8'd0;
            // Stop decisions look at the floor just reached, not the one left.
            if (|(stop_req & stepPos)) begin
              nxtState = OPENING;
            end else if ((stepPos == endPos) || (ud_mode != dirMode)) begin
              nxtState = IDLE;
            end else begin
              nxtState = curState;
            end
          end else begin
            nxtState = curState;
          end
        end
        OPENING: begin
          if (cnt == DMOVE_LAST) begin
            nxtState  = OPEN;
            nxtCnt    = 8'd0;
            nxtServed = position;
          end else begin
            nxtState = OPENING;
          end
        end
        OPEN: begin
          if (open_btn || obstruct) begin
            nxtCnt = 8'd0;
          end else if (close_btn || (cnt == DWELL_LAST)) begin
            nxtState = CLOSING;
            nxtCnt   = 8'd0;
          end else begin
            nxtState = OPEN;
          end
        end
        CLOSING: begin
          if (obstruct || open_btn) begin
            nxtState = OPENING;
            nxtCnt   = 8'd0;
          end else if (cnt == DMOVE_LAST) begin
            nxtState = IDLE;
            nxtCnt   = 8'd0;
          end else begin
            nxtState = CLOSING;
          end
        end
        default: begin
          nxtState = IDLE;
          nxtCnt   = 8'd0;
        end
      endcase
    end
  end

  // State register with outputs decoded from the next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState  <= IDLE;
      cnt       <= 8'd0;
      position  <= 4'b0001;
      motor_up  <= 1'b0;
      motor_dn  <= 1'b0;
      door_open <= 1'b0;
      arrive    <= 1'b0;
      served    <= 4'b0000;
    end else begin
      curState  <= nxtState;
      cnt       <= nxtCnt;
      position  <= nxtPos;
      motor_up  <= (nxtState == MOVE_UP);
      motor_dn  <= (nxtState == MOVE_DN);
      door_open <= (nxtState == OPEN);
      arrive    <= nxtArrive;
      served    <= nxtServed;
    end
  end

endmodule
